// File: rtl/wb_mem_tester_pkg.sv
// wb_mem_tester shared types: FSM states and the pattern LFSR step.
// Optional watchdog build: define WB_MEM_TESTER_TIMEOUT_EN.
package wb_mem_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_DRAIN,
    GAP,
    RD_ISSUE,
    RD_DRAIN,
    FIN
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    lfsr_next = (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/wb_mem_tester_lfsr.sv
// 32-bit Galois LFSR with load priority over step.
// Used twice: issue-side write data and read-side expected data.
module wb_mem_tester_lfsr
  import wb_mem_tester_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (rst)       value <= '0;
    else if (load) value <= seed;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone B4 pipelined memory tester: LFSR fill, read back, compare.
// Define WB_MEM_TESTER_TIMEOUT_EN to add a 10-bit response watchdog.
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter int ADDR_W          = 28,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_adr,
  input  logic [ADDR_W-1:0]    num_words,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_adr,
  output logic                 bus_err,
  output logic [ADDR_W-1:0]    wb_adr,
  output logic [31:0]          wb_dat_w,
  input  logic [31:0]          wb_dat_r,
  output logic [3:0]           wb_sel,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  input  logic                 wb_stall,
  input  logic                 wb_ack,
  input  logic                 wb_err
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_r, num_r, adr, rsp_adr, issued;
  logic [31:0]       seed_r, seed_fix, lfsr_seed, iss_val, chk_val;
  logic [3:0]        outst;
  logic              cap, pass_r;
  logic              active, issuing, rd_phase, stb, accept;
  logic              resp, err_ev, chk_ev, last_acc, go, ld, wd_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    seed_fix  = (seed == 32'h0) ? 32'h1 : seed;
    lfsr_seed = (state == IDLE) ? seed_fix : seed_r;
    issuing   = (state == WR_ISSUE) || (state == RD_ISSUE);
    rd_phase  = (state == RD_ISSUE) || (state == RD_DRAIN);
    active    = issuing || (state == WR_DRAIN) || rd_phase;
    stb       = issuing && !bus_err && (issued < num_r)
                && (outst < 4'(MAX_OUTSTANDING));
    accept    = stb && !wb_stall;
    resp      = active && (outst != '0) && (wb_ack || wb_err);
    err_ev    = resp && wb_err;
    chk_ev    = resp && wb_ack && !wb_err && rd_phase;
    last_acc  = accept && ((issued + ADDR_W'(1)) == num_r);
    go        = (state == IDLE) && start;
    ld        = go || (state == GAP);
    state_nx  = state;
    unique case (state)
      IDLE:     if (start) state_nx = (num_words == '0) ? FIN : WR_ISSUE;
      WR_ISSUE: if (last_acc || err_ev) state_nx = WR_DRAIN;
      WR_DRAIN: if (outst == '0) state_nx = bus_err ? FIN : GAP;
      GAP:      state_nx = RD_ISSUE;
      RD_ISSUE: if (last_acc || err_ev) state_nx = RD_DRAIN;
      RD_DRAIN: if (outst == '0) state_nx = FIN;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (wd_hit) state_nx = FIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= '0; num_r <= '0; seed_r <= '0;
      adr <= '0; rsp_adr <= '0; issued <= '0;
      outst <= '0; err_count <= '0; first_err_adr <= '0;
      cap <= 1'b0; bus_err <= 1'b0; pass_r <= 1'b0;
    end else if (go) begin
      base_r <= base_adr; num_r <= num_words; seed_r <= seed_fix;
      adr <= base_adr; rsp_adr <= base_adr; issued <= '0;
      outst <= '0; err_count <= '0; first_err_adr <= '0;
      cap <= 1'b0; bus_err <= 1'b0;
      pass_r <= (num_words == '0);
    end else if (state == GAP) begin
      adr <= base_r; rsp_adr <= base_r; issued <= '0;
    end else begin
      if (accept) begin
        adr    <= adr + ADDR_W'(1);
        issued <= issued + ADDR_W'(1);
      end
      if (resp) rsp_adr <= rsp_adr + ADDR_W'(1);
      if (accept && !resp) outst <= outst + 4'd1;
      if (!accept && resp) outst <= outst - 4'd1;
      if (chk_ev && (wb_dat_r != chk_val)) begin
        if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
        if (!cap) begin first_err_adr <= rsp_adr; cap <= 1'b1; end
      end
      if (err_ev) begin
        bus_err <= 1'b1;
        if (!cap) begin first_err_adr <= rsp_adr; cap <= 1'b1; end
      end
      // Result is frozen on the way into FIN; nothing is in flight then.
      if (state_nx == FIN && state != FIN)
        pass_r <= !wd_hit && !bus_err && (err_count == '0);
      if (wd_hit) begin
        outst   <= '0;
        bus_err <= 1'b1;
      end
    end
  end

`ifdef WB_MEM_TESTER_TIMEOUT_EN
  logic [9:0] wd;

  always_ff @(posedge clk) begin
    if (rst || go || resp || !active) wd <= '0;
    else if (outst != '0)             wd <= wd + 10'd1;
  end

  assign wd_hit = active && (wd == 10'h3ff);
`else
  assign wd_hit = 1'b0;
`endif

  wb_mem_tester_lfsr u_iss (
    .clk(clk), .rst(rst), .load(ld), .step(accept),
    .seed(lfsr_seed), .value(iss_val)
  );

  wb_mem_tester_lfsr u_chk (
    .clk(clk), .rst(rst), .load(ld), .step(chk_ev),
    .seed(lfsr_seed), .value(chk_val)
  );

  assign busy     = (state != IDLE) && (state != FIN);
  assign done     = (state == FIN);
  assign pass     = pass_r;
  assign wb_cyc   = active && !rst;
  assign wb_stb   = stb && !rst;
  assign wb_we    = wb_stb && (state == WR_ISSUE);
  assign wb_sel   = {4{wb_stb}};
  assign wb_adr   = adr;
  assign wb_dat_w = iss_val;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Randomized bench for wb_mem_tester: pipelined slave model with memory,
// stalls, latency, corruption and error injection.
module tb_wb_mem_tester;

  logic        clk, rst, start;
  logic [27:0] base_adr, num_words;
  logic [31:0] seed;
  logic        busy, done, pass, bus_err;
  logic [15:0] err_count;
  logic [27:0] first_err_adr, wb_adr;
  logic [31:0] wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we, wb_stall, wb_ack, wb_err;

  wb_mem_tester #(.ADDR_W(28), .MAX_OUTSTANDING(4), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_adr(first_err_adr),
    .bus_err(bus_err), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w),
    .wb_dat_r(wb_dat_r), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_stall(wb_stall),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] v);
    logic [31:0] r;
    r = {1'b0, v[31:1]};
    if (v[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  typedef struct {
    logic        is_err;
    logic [31:0] d;
    int          ready;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem [logic [27:0]];
  int          cyc = 0;
  int          stall_pct = 0, lat = 1, err_idx = -1;
  bit          corrupt_en = 0, hang = 0;
  logic [27:0] corrupt_adr = '0;
  int          acc_cnt, rd_acc, cyc_hi, max_seen, unstable, sel_bad;
  bit          prev_st = 0;
  logic [27:0] s_adr;
  logic [31:0] s_dat;
  logic        s_we;

  always @(negedge clk) begin
    rsp_t r;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
    if (q.size() > 0 && q[0].ready <= cyc) begin
      r = q.pop_front();
      wb_ack = !r.is_err; wb_err = r.is_err; wb_dat_r = r.d;
    end
    wb_stall = ($urandom_range(99) < stall_pct);
    if (wb_stb && wb_sel != 4'hF) sel_bad++;
    if (prev_st && wb_stb &&
        (wb_adr != s_adr || wb_dat_w != s_dat || wb_we != s_we))
      unstable++;
    prev_st = wb_stb && wb_stall;
    s_adr = wb_adr; s_dat = wb_dat_w; s_we = wb_we;
    if (wb_cyc) cyc_hi++;
    if (wb_cyc && wb_stb && !wb_stall) begin
      r.is_err = (acc_cnt == err_idx);
      r.d = '0;
      if (wb_we) begin
        if (!r.is_err) mem[wb_adr] = wb_dat_w;
      end else begin
        rd_acc++;
        if (mem.exists(wb_adr)) r.d = mem[wb_adr];
        if (corrupt_en && wb_adr == corrupt_adr) r.d[0] = ~r.d[0];
      end
      r.ready = hang ? 32'h7fffffff : cyc + lat;
      q.push_back(r);
      acc_cnt++;
    end
    if (q.size() > max_seen) max_seen = q.size();
    cyc++;
  end

  task automatic run(input logic [27:0] b, input logic [27:0] n,
                     input logic [31:0] sd, input int sp, input int lt,
                     input bit cen, input logic [27:0] cadr,
                     input int eidx, output int dcyc);
    logic [31:0] exp_q[$];
    logic [31:0] p;
    logic [27:0] off, fadr_e;
    int          err_e, bad;
    bit          bus_e, pass_e;
    stall_pct = sp; lat = lt; corrupt_en = cen; corrupt_adr = cadr;
    err_idx = eidx;
    acc_cnt = 0; rd_acc = 0; cyc_hi = 0; max_seen = 0;
    unstable = 0; sel_bad = 0;
    p = (sd == 32'h0) ? 32'h1 : sd;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(p);
      p = ref_next(p);
    end
    @(negedge clk);
    start = 1'b1; base_adr = b; num_words = n; seed = sd;
    @(negedge clk);
    start = 1'b0;
    dcyc = 1;
    if (n != 0) chk("busy_after_start", busy, 1);
    while (!done && dcyc < 5000) begin
      @(negedge clk);
      dcyc++;
    end
    chk("done_seen", done, 1);
    err_e = 0; bus_e = 0; fadr_e = '0;
    off = cadr - b;
    if (eidx >= 0 && eidx < int'(n)) begin
      bus_e = 1; fadr_e = b + 28'(eidx);
    end else if (cen && off < n) begin
      err_e = 1; fadr_e = cadr;
    end
    pass_e = (err_e == 0) && !bus_e;
    chk("pass", pass, pass_e);
    chk("err_count", err_count, err_e);
    chk("bus_err", bus_err, bus_e);
    if (!pass_e) chk("first_err_adr", first_err_adr, fadr_e);
    if (bus_e) begin
      chk("no_read_phase", rd_acc, 0);
    end else begin
      bad = 0;
      for (int i = 0; i < int'(n); i++)
        if (!mem.exists(b + 28'(i)) || mem[b + 28'(i)] !== exp_q[i]) bad++;
      chk("write_data", bad, 0);
      chk("reads_issued", rd_acc, n);
    end
    chk("max_outstanding", max_seen <= 4, 1);
    chk("stall_stable", unstable, 0);
    chk("sel_f", sel_bad, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("pass_hold", pass, pass_e);
  endtask

  int d;
  int bad;
  logic [27:0] rb, rn;

  initial begin
    rst = 1'b1; start = 1'b0; base_adr = '0; num_words = '0; seed = '0;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy, done, pass, bus_err, wb_cyc, wb_stb, wb_we,
                      wb_sel, err_count, first_err_adr}, 0);
    chk("reset_bus", {wb_adr, wb_dat_w}, 0);
    rst = 1'b0;

    run(28'h100, 28'd16, 32'h1, 0, 1, 0, '0, -1, d);
    chk("zero_wait_latency", (d >= 30 && d <= 45), 1);

    run(28'h100, 28'd16, 32'h1234, 50, 3, 0, '0, -1, d);
    run(28'h100, 28'd16, 32'h1, 0, 1, 1, 28'h105, -1, d);
    run(28'h100, 28'd16, 32'hcafe, 20, 2, 0, '0, 2, d);

    run(28'h200, 28'd0, 32'h5, 0, 1, 0, '0, -1, d);
    chk("zero_len_latency", d, 1);
    chk("zero_len_no_cyc", cyc_hi, 0);

    for (int t = 0; t < 8; t++) begin
      rb = (t == 1) ? 28'hffffff8 : 28'($urandom);
      rn = 28'($urandom_range(1, 40));
      if (t % 3 == 2)
        run(rb, rn, $urandom, $urandom_range(0, 60), $urandom_range(1, 4),
            0, '0, $urandom_range(0, int'(rn) - 1), d);
      else
        run(rb, rn, (t == 0) ? 32'h0 : $urandom, $urandom_range(0, 60),
            $urandom_range(1, 4), 1'($urandom_range(0, 1)),
            rb + 28'($urandom_range(0, int'(rn) - 1)), -1, d);
    end

    stall_pct = 0; lat = 2; corrupt_en = 0; err_idx = -1;
    @(negedge clk);
    start = 1'b1; base_adr = 28'h300; num_words = 28'd24; seed = 32'h77;
    @(negedge clk);
    start = 1'b0;
    d = 0;
    while (!(wb_cyc && wb_stb && !wb_we) && d < 200) begin
      @(negedge clk);
      d++;
    end
    chk("reached_read_phase", d < 200, 1);
    rst = 1'b1;
    #1;
    chk("rst_drops_cyc_stb", {wb_cyc, wb_stb}, 0);
    @(negedge clk);
    chk("midrst_ctl", {busy, done, pass, bus_err, wb_cyc, wb_stb, wb_we,
                       wb_sel, err_count, first_err_adr}, 0);
    chk("midrst_bus", {wb_adr, wb_dat_w}, 0);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done || bus_err || wb_cyc || err_count != 0) bad++;
    end
    chk("stale_acks_ignored", bad, 0);
    q.delete();

`ifdef WB_MEM_TESTER_TIMEOUT_EN
    hang = 1; stall_pct = 0;
    @(negedge clk);
    start = 1'b1; base_adr = 28'h400; num_words = 28'd4; seed = 32'h9;
    @(negedge clk);
    start = 1'b0;
    d = 1;
    while (!done && d < 1500) begin
      @(negedge clk);
      d++;
    end
    chk("timeout_done", done, 1);
    chk("timeout_bus_err", bus_err, 1);
    chk("timeout_latency", (d >= 1020 && d <= 1035), 1);
    chk("timeout_pass", pass, 0);
    hang = 0;
    q.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
